mem_access_unit: RTL and testbench

//  MEM-stage load/store initiator driving the word-indexed DataMemory port (memRead/memWrite/address/writeData/readData).

---
 rtl/mem_access_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 117 +++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and byte-lane constants for the MEM-stage load/store unit.
// The optional MEM_ACCESS_MISALIGN_CHECK_EN feature uses is_misaligned().
package mem_access_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic size_t to_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: sub-word store merge into the read-back
// word, and load extraction with sign/zero extension.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] rd_buf_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  size_t             size_i,
  input  logic [1:0]        offset_i,
  input  logic              unsigned_i,
  output logic [WORD_W-1:0] merged_o,
  output logic [WORD_W-1:0] load_o
);

  logic [BYTE_W-1:0] sel_byte;
  logic [HALF_W-1:0] sel_half;

  always_comb begin
    sel_byte = rd_buf_i[BYTE_W*offset_i +: BYTE_W];
    sel_half = rd_buf_i[HALF_W*offset_i[1] +: HALF_W];
    merged_o = rd_buf_i;
    load_o   = rd_buf_i;
    case (size_i)
      SZ_BYTE: begin
        merged_o[BYTE_W*offset_i +: BYTE_W] = wdata_i[BYTE_W-1:0];
        load_o = unsigned_i ? {{(WORD_W-BYTE_W){1'b0}}, sel_byte}
                            : {{(WORD_W-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
      end
      SZ_HALF: begin
        merged_o[HALF_W*offset_i[1] +: HALF_W] = wdata_i[HALF_W-1:0];
        load_o = unsigned_i ? {{(WORD_W-HALF_W){1'b0}}, sel_half}
                            : {{(WORD_W-HALF_W){sel_half[HALF_W-1]}}, sel_half};
      end
      default: begin
        merged_o = wdata_i;
        load_o   = rd_buf_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with read-modify-write for sub-word stores.
// Define MEM_ACCESS_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqUnsigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspRData,
  output logic              rspErr,
  output logic              busy,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
);

  state_t            state_q, state_d;
  logic              write_q, unsigned_q, err_q;
  size_t             size_q;
  logic [1:0]        off_q;
  logic [MEM_AW-1:0] widx_q;
  logic [DATA_W-1:0] wdata_q, rdbuf_q;
  logic [DATA_W-1:0] merged, load_data;
  logic              accept, misalign_req;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^reqAddr[ADDR_W-1:MEM_AW+2];
  assign accept = (state_q == IDLE) && reqValid;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign misalign_req = is_misaligned(to_size(reqSize), reqAddr[1:0]);
`else
  assign misalign_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          if (misalign_req)                             state_d = RESP;
          else if (reqWrite && to_size(reqSize) == SZ_WORD) state_d = WRITE;
          else                                          state_d = READ;
        end
      end
      READ:    state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= '0;
      widx_q     <= '0;
      wdata_q    <= '0;
      rdbuf_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= reqWrite;
        unsigned_q <= reqUnsigned;
        err_q      <= misalign_req;
        size_q     <= to_size(reqSize);
        off_q      <= reqAddr[1:0];
        widx_q     <= reqAddr[MEM_AW+1:2];
        wdata_q    <= reqWData;
      end
      if (state_q == READ) rdbuf_q <= memReadData;
    end
  end

  mem_lane_align u_align (
    .rd_buf_i   (rdbuf_q),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .offset_i   (off_q),
    .unsigned_i (unsigned_q),
    .merged_o   (merged),
    .load_o     (load_data)
  );

  // Memory-side outputs are pure state decodes so reset drops them at once.
  assign reqReady     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign memRead      = (state_q == READ);
  assign memWrite     = (state_q == WRITE);
  assign memAddress   = (memRead || memWrite) ? {{(ADDR_W-MEM_AW){1'b0}}, widx_q} : '0;
  assign memWriteData = memWrite ? merged : '0;
  assign rspValid     = (state_q == RESP);
  assign rspRData     = (rspValid && !write_q && !err_q) ? load_data : '0;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  assign rspErr = rspValid && err_q;
`else
  assign rspErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word-array memory model.
// Covers both builds of MEM_ACCESS_MISALIGN_CHECK_EN.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqUnsigned = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic [31:0] reqAddr = '0, reqWData = '0;
  logic        reqReady, rspValid, rspErr, busy, memRead, memWrite;
  logic [31:0] rspRData, memAddress, memWriteData, memReadData;

  logic [31:0] mem_m [0:1023];
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;

  int          checks = 0, errors = 0;
  int          r_lat, r_drd, r_dwr;
  logic [31:0] r_data;
  logic        r_err;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
    .reqWData(reqWData), .rspValid(rspValid), .rspRData(rspRData),
    .rspErr(rspErr), .busy(busy), .memRead(memRead), .memWrite(memWrite),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  assign memReadData = mem_m[memAddress[9:0]];

  always @(posedge clk)
    if (memWrite) mem_m[memAddress[9:0]] <= memWriteData;

  always @(negedge clk) begin
    if (memRead) rd_cnt <= rd_cnt + 1;
    if (memWrite) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= memAddress;
      last_wdata <= memWriteData;
    end
    if (memRead && memWrite) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response, and leave the unit back in IDLE.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
    int rd0, wr0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = uns;
    reqAddr = a; reqWData = d;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk); #1;
    reqValid = 1'b0;
    r_lat = 0; r_data = 'x; r_err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      if (rspValid) begin
        r_lat = i; r_data = rspRData; r_err = rspErr;
        break;
      end
      @(posedge clk); #1;
    end
    r_drd = rd_cnt - rd0;
    r_dwr = wr_cnt - wr0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    #12;
    chk("rst_memRead", memRead, 0);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_rspValid", rspValid, 0);
    chk("rst_rspErr", rspErr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_memAddress", memAddress, 0);
    chk("rst_memWriteData", memWriteData, 0);
    chk("rst_rspRData", rspRData, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_reqReady", reqReady, 1);

    // SW to word 2
    do_req(1, 2'b10, 0, 32'h8, 32'hDEADBEEF);
    chk("sw_lat", r_lat, 2);
    chk("sw_writes", r_dwr, 1);
    chk("sw_reads", r_drd, 0);
    chk("sw_waddr", last_waddr, 2);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_rdata", r_data, 0);
    chk("sw_err", r_err, 0);
    do_req(1, 2'b10, 0, 32'h4, 32'h11223344);
    chk("sw1_lat", r_lat, 2);

    // Loads from 0xDEADBEEF
    do_req(0, 2'b00, 0, 32'h9, 0);
    chk("lb9_data", r_data, 32'hFFFFFFBE);
    chk("lb9_lat", r_lat, 2);
    chk("lb9_reads", r_drd, 1);
    chk("lb9_writes", r_dwr, 0);
    do_req(0, 2'b00, 1, 32'h9, 0);
    chk("lbu9_data", r_data, 32'h000000BE);
    do_req(0, 2'b01, 1, 32'hA, 0);
    chk("lhuA_data", r_data, 32'h0000DEAD);
    do_req(0, 2'b01, 0, 32'h8, 0);
    chk("lh8_data", r_data, 32'hFFFFBEEF);
    do_req(0, 2'b00, 0, 32'hB, 0);
    chk("lbB_data", r_data, 32'hFFFFFFDE);
    do_req(0, 2'b00, 1, 32'h8, 0);
    chk("lbu8_data", r_data, 32'h000000EF);
    do_req(0, 2'b10, 0, 32'h8, 0);
    chk("lw8_data", r_data, 32'hDEADBEEF);
    chk("lw8_lat", r_lat, 2);

    // Sub-word stores use read-modify-write
    do_req(1, 2'b00, 0, 32'hB, 32'h00000012);
    chk("sbB_lat", r_lat, 3);
    chk("sbB_reads", r_drd, 1);
    chk("sbB_writes", r_dwr, 1);
    chk("sbB_waddr", last_waddr, 2);
    chk("sbB_wdata", last_wdata, 32'h12ADBEEF);
    chk("sbB_rdata", r_data, 0);
    do_req(1, 2'b01, 0, 32'h8, 32'hFFFF5678);
    chk("sh8_lat", r_lat, 3);
    chk("sh8_wdata", last_wdata, 32'h12AD5678);
    do_req(0, 2'b10, 0, 32'h1008, 0);
    chk("lw_wrap_data", r_data, 32'h12AD5678);

    // Back-to-back SW then LW with reqValid held high
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0;
    reqAddr = 32'h10; reqWData = 32'hA5A55A5A;
    @(posedge clk); #1;
    reqWrite = 1'b0; reqWData = 32'h0;
    chk("b2b_ready_busy", reqReady, 0);
    chk("b2b_busy", busy, 1);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (rspValid) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("b2b_sw_rsp", found, 1);
    @(posedge clk); #1;
    chk("b2b_ready_idle", reqReady, 1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    found = 0; r_data = 'x;
    for (int i = 0; i < 8; i++) begin
      if (rspValid) begin found = 1; r_data = rspRData; break; end
      @(posedge clk); #1;
    end
    chk("b2b_lw_rsp", found, 1);
    chk("b2b_lw_data", r_data, 32'hA5A55A5A);
    @(posedge clk); #1;

    // Reset during the WRITE phase of an SH
    do_req(1, 2'b10, 0, 32'hC, 32'hCAFEF00D);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b01; reqUnsigned = 1'b0;
    reqAddr = 32'hE; reqWData = 32'h00001234;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_pre_write", memWrite, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstw_memWrite", memWrite, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_memAddress", memAddress, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    chk("rstw_mem_word", mem_m[3], 32'hCAFEF00D);
    do_req(0, 2'b10, 0, 32'hC, 0);
    chk("rstw_lw_data", r_data, 32'hCAFEF00D);

    // Misaligned word load
    do_req(0, 2'b10, 0, 32'h6, 0);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    chk("mis_lat", r_lat, 1);
    chk("mis_err", r_err, 1);
    chk("mis_data", r_data, 0);
    chk("mis_reads", r_drd, 0);
`else
    chk("mis_lat", r_lat, 2);
    chk("mis_err", r_err, 0);
    chk("mis_data", r_data, 32'h11223344);
    chk("mis_reads", r_drd, 1);
`endif

    chk("rw_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
